// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD window controller.
//   lcd_state_t   write-cycle sequencer states
//   LCD_*_BIT     field positions inside the 32-bit store word
//   STAT_*_BIT    field positions inside the 32-bit status word
//   max_u()       helper used to size the shared down-counter
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EN    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_EXEC  = 3'd5
  } lcd_state_t;

  localparam int unsigned LCD_WORD_W   = 32;
  localparam int unsigned LCD_ON_BIT   = 31;
  localparam int unsigned LCD_RS_BIT   = 9;
  localparam int unsigned LCD_DATA_MSB = 7;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DROP_BIT = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns each accepted LCD-window store into one HD44780 8-bit
// write cycle (setup, EN pulse, hold, execution wait) and exposes a status
// word for the load path.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_lcd_wr       one-cycle store strobe
//   i_lcd_word     [31] power, [9] RS, [7:0] DATA
//   o_lcd_data/rs/rw/en/on  LCD pins (rw tied low)
//   o_busy         high whenever a store would be dropped
//   o_status       {30'b0, drop_sticky, o_busy}
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_CYC      = 12,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned EXEC_CYC    = 2000,
  parameter int unsigned CLEAR_CYC   = 82000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_lcd_wr,
  input  logic [LCD_WORD_W-1:0] i_lcd_word,
  output logic [7:0]            o_lcd_data,
  output logic                  o_lcd_rs,
  output logic                  o_lcd_rw,
  output logic                  o_lcd_en,
  output logic                  o_lcd_on,
  output logic                  o_busy,
  output logic [LCD_WORD_W-1:0] o_status
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(POWERUP_CYC, SETUP_CYC), max_u(EN_CYC, HOLD_CYC)),
                                          max_u(EXEC_CYC, CLEAR_CYC));
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter reload values: each state lasts N cycles, counting N-1 .. 0.
  localparam cnt_t PWRUP_LD = cnt_t'(POWERUP_CYC - 1);
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EN_LD    = cnt_t'(EN_CYC - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t EXEC_LD  = cnt_t'(EXEC_CYC - 1);
  localparam cnt_t CLEAR_LD = cnt_t'(CLEAR_CYC - 1);

  lcd_state_t state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic       accept;
  logic       is_clear;
  logic       drop_sticky;

  logic [7:0] wr_data;
  logic       wr_rs;
  logic       wr_is_clear;
  logic       unused_word_bits;

  assign wr_data = i_lcd_word[LCD_DATA_MSB:0];
  assign wr_rs   = i_lcd_word[LCD_RS_BIT];

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign wr_is_clear = !wr_rs && (wr_data[7:2] == 6'd0) && (wr_data[1:0] != 2'd0);

  assign unused_word_bits = ^{i_lcd_word[LCD_ON_BIT-1:LCD_RS_BIT+1], i_lcd_word[LCD_RS_BIT-1:LCD_DATA_MSB+1]};

  wire cnt_zero = (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? cnt : cnt - cnt_t'(1);
    accept    = 1'b0;
    unique case (state)
      ST_PWRUP: if (cnt_zero) state_nxt = ST_IDLE;
      ST_IDLE: begin
        cnt_nxt = cnt;
        if (i_lcd_wr) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: if (cnt_zero) begin state_nxt = ST_EN;   cnt_nxt = EN_LD;   end
      ST_EN:    if (cnt_zero) begin state_nxt = ST_HOLD; cnt_nxt = HOLD_LD; end
      ST_HOLD:  if (cnt_zero) begin
        state_nxt = ST_EXEC;
        cnt_nxt   = is_clear ? CLEAR_LD : EXEC_LD;
      end
      ST_EXEC:  if (cnt_zero) state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_PWRUP;
        cnt_nxt   = PWRUP_LD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_PWRUP;
      cnt         <= PWRUP_LD;
      o_lcd_data  <= '0;
      o_lcd_rs    <= 1'b0;
      o_lcd_on    <= 1'b0;
      is_clear    <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        o_lcd_data <= wr_data;
        o_lcd_rs   <= wr_rs;
        o_lcd_on   <= i_lcd_word[LCD_ON_BIT];
        is_clear   <= wr_is_clear;
      end
      // Any strobe outside IDLE is lost; remember it for software.
      if (i_lcd_wr && (state != ST_IDLE)) drop_sticky <= 1'b1;
    end
  end

  assign o_lcd_rw = 1'b0;
  assign o_lcd_en = (state == ST_EN);
  assign o_busy   = (state != ST_IDLE);

  always_comb begin
    o_status                = '0;
    o_status[STAT_BUSY_BIT] = o_busy;
    o_status[STAT_DROP_BIT] = drop_sticky;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Peripheral-side controller for the LCD window (0x7030–0x703F) of the memory-mapped I/O map. The load/store unit produces the 32-bit LCD word and a one-cycle store strobe. This block turns each accepted word into one HD44780-compatible 8-bit write cycle, with setup, enable-pulse, hold and execution delays. It also returns a status word that the load path reads from the same window.

## Interface
Parameters:
- POWERUP_CYC, 750000, cycles of busy after reset (15 ms at 50 MHz)
- SETUP_CYC, 2, RS/DATA stable before EN rises (≥1)
- EN_CYC, 12, EN high width (≥1)
- HOLD_CYC, 1, RS/DATA held after EN falls (≥1)
- EXEC_CYC, 2000, post-write busy for normal commands/data (40 µs)
- CLEAR_CYC, 82000, post-write busy for clear/home (1.64 ms)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_lcd_wr  in  1  one-cycle store strobe for the LCD window
- i_lcd_word  in  32  store data: [31] display power, [9] RS, [7:0] DATA; other bits ignored
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  constant 0 (write-only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  display power
- o_busy  out  1  high when a write would be dropped
- o_status  out  32  {30'b0, drop_sticky, o_busy}

## Operation
- States: PWRUP, IDLE, SETUP, EN, HOLD, EXEC. A single down-counter times every state.
- Reset:
  - State is PWRUP and the counter is loaded with POWERUP_CYC−1.
  - All outputs are 0, except o_busy = 1.
  - drop_sticky is cleared.
- PWRUP: when the counter reaches 0, go to IDLE.
- IDLE with i_lcd_wr = 1:
  - Capture DATA into o_lcd_data, RS into o_lcd_rs and bit 31 into o_lcd_on.
  - Set is_clear = (RS==0 && DATA[7:2]==0 && DATA[1:0]!=0), i.e. 0x01/0x02/0x03.
  - Go to SETUP and load SETUP_CYC−1.
- SETUP → EN: on counter 0; load EN_CYC−1.
- EN → HOLD: on counter 0; load HOLD_CYC−1. o_lcd_en = 1 only while in EN.
- HOLD → EXEC: on counter 0; load (is_clear ? CLEAR_CYC : EXEC_CYC)−1.
- EXEC → IDLE: on counter 0.
- o_busy = 1 in every state except IDLE.
- i_lcd_wr while o_busy = 1:
  - The write is dropped and captured registers are unchanged.
  - drop_sticky is set and stays set until reset.
- o_lcd_data and o_lcd_rs hold their value from capture until the next accepted write.
- Counter width: $clog2 of the largest parameter. Counting is down only, with no wrap.

## Timing
- Write strobed at edge N in IDLE:
  - Edge N+1: o_busy = 1 and data/RS are valid.
  - EN rises after SETUP_CYC cycles and stays high EN_CYC cycles.
  - Busy time is SETUP+EN+HOLD+EXEC(or CLEAR) cycles. o_busy falls at the edge that enters IDLE.
- A write in the same cycle that IDLE is entered is accepted; a write one cycle earlier (EXEC, counter 0) is dropped.
- Reset asserted mid-transfer:
  - o_lcd_en = 0 and state is PWRUP at the next edge.
  - Full POWERUP_CYC wait follows.
- Reset dominates i_lcd_wr.
- o_status is registered-source combinational: no extra latency.

## Structure
- lcd_pkg:
  - State enum lcd_state_t.
  - Bit-position constants LCD_ON_BIT=31, LCD_RS_BIT=9, LCD_DATA_MSB=7.
  - Status bit constants.
- Single module; no sub-module needed (counter is inline).

## Test plan
Bench parameters: POWERUP_CYC=10, SETUP_CYC=2, EN_CYC=3, HOLD_CYC=1, EXEC_CYC=5, CLEAR_CYC=20.
- Reset released: o_busy = 1 for exactly 10 cycles; all outputs 0; then IDLE.
- Write 0x8000_0241 in IDLE:
  - Next edge: rs = 1, data = 0x41, on = 1.
  - en high for exactly 3 cycles, starting 2 cycles after capture.
  - o_busy high for 11 cycles total.
- Write 0x0000_0001 (clear): busy for 2+3+1+20 = 26 cycles. Write 0x0000_0038: busy 11 cycles.
- Second write during EN:
  - data/rs unchanged.
  - o_status = 0x3 while busy, 0x2 after IDLE.
  - drop_sticky persists until reset.
- Reset asserted during EN: o_lcd_en = 0 next edge, busy for 10 cycles, o_status bit 1 cleared.
- Write strobed exactly on the IDLE-entry cycle is accepted; strobe one cycle earlier is dropped.
